// File: rtl/rdma_rx_dispatch.sv
// rtl/rdma_rx_dispatch.sv - classify inbound RDMA headers and push each one to its local queue
// One-entry holding register; unknown opcodes or a nonzero RV field are dropped and counted.
module rdma_rx_dispatch #(
    parameter int TID_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hdrValid,
    output logic             hdrReady,
    input  logic [15:0]      hdrControl,
    input  logic [51:0]      hdrWR,
    output logic             reqPush,
    output logic [51:0]      reqData,
    input  logic             reqFull,
    output logic             ackFifoPush,
    output logic [27:0]      ackFifoDataIn,
    input  logic             ackFifoFull,
    output logic             offloadFifoPush,
    output logic [7:0]       offloadFifoDataIn,
    input  logic             offloadFifoFull,
    output logic             wrDoneFifoPush,
    output logic [7:0]       wrDoneFifoDataIn,
    input  logic             wrDoneFifoFull,
    output logic [7:0]       dropCnt,
    output logic             ackSeqErr,
    output logic [CNT_W-1:0] sendCnt,
    output logic [CNT_W-1:0] rcvCnt,
    output logic [CNT_W-1:0] reqCnt,
    output logic [CNT_W-1:0] ackCnt
);

    localparam logic [3:0] OP_SEND = 4'b0000;
    localparam logic [3:0] OP_RCV  = 4'b0001;
    localparam logic [3:0] OP_REQ  = 4'b0011;
    localparam logic [3:0] OP_ACK  = 4'b0111;

    typedef enum logic {S_EMPTY, S_LOADED} state_e;

    state_e             state_q, state_d;
    logic [1:0]         rv_q, rv_d;
    logic [3:0]         op_q, op_d;
    logic [51:0]        wr_q, wr_d;
    logic [7:0]         drop_q, drop_d;
    logic               err_q, err_d;
    logic [TID_W-1:0]   exp_tid_q, exp_tid_d;
    logic [CNT_W-1:0]   send_q, send_d, rcv_q, rcv_d, req_q, req_d, ack_q, ack_d;

    logic loaded, is_send, is_rcv, is_req, is_ack, is_drop, target_full, retire, accept;
    logic [TID_W-1:0] held_tid;
    logic unused_ctrl;

    assign unused_ctrl = ^{hdrControl[15:8], hdrControl[5:4]};

    assign loaded   = (state_q == S_LOADED);
    assign is_send  = (rv_q == 2'b00) && (op_q == OP_SEND);
    assign is_rcv   = (rv_q == 2'b00) && (op_q == OP_RCV);
    assign is_req   = (rv_q == 2'b00) && (op_q == OP_REQ);
    assign is_ack   = (rv_q == 2'b00) && (op_q == OP_ACK);
    assign is_drop  = !(is_send || is_rcv || is_req || is_ack);
    assign held_tid = wr_q[51 -: TID_W];

    assign target_full = (is_send && offloadFifoFull) || (is_rcv && wrDoneFifoFull) ||
                         (is_req && reqFull) || (is_ack && ackFifoFull);

    // Drops retire unconditionally so a full queue never blocks garbage from draining.
    assign retire   = loaded && (is_drop || !target_full);
    assign hdrReady = !loaded || retire;
    assign accept   = hdrValid && hdrReady;

    assign offloadFifoPush = loaded && is_send && !offloadFifoFull;
    assign wrDoneFifoPush  = loaded && is_rcv  && !wrDoneFifoFull;
    assign reqPush         = loaded && is_req  && !reqFull;
    assign ackFifoPush     = loaded && is_ack  && !ackFifoFull;

    assign reqData           = wr_q;
    assign ackFifoDataIn     = wr_q[51:24];
    assign offloadFifoDataIn = wr_q[51:44];
    assign wrDoneFifoDataIn  = wr_q[51:44];

    assign dropCnt   = drop_q;
    assign ackSeqErr = err_q;
    assign sendCnt   = send_q;
    assign rcvCnt    = rcv_q;
    assign reqCnt    = req_q;
    assign ackCnt    = ack_q;

    always_comb begin
        state_d   = state_q;
        rv_d      = rv_q;
        op_d      = op_q;
        wr_d      = wr_q;
        drop_d    = drop_q;
        err_d     = err_q;
        exp_tid_d = exp_tid_q;
        send_d    = send_q;
        rcv_d     = rcv_q;
        req_d     = req_q;
        ack_d     = ack_q;

        if (accept) begin
            rv_d    = hdrControl[7:6];
            op_d    = hdrControl[3:0];
            wr_d    = hdrWR;
            state_d = S_LOADED;
        end else if (retire) begin
            state_d = S_EMPTY;
        end

        if (loaded && is_drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

        // Resynchronise to whatever TID arrived so one gap flags once, not forever.
        if (ackFifoPush) begin
            if (held_tid != exp_tid_q) err_d = 1'b1;
            exp_tid_d = held_tid + TID_W'(1);
            ack_d     = ack_q + CNT_W'(1);
        end
        if (offloadFifoPush) send_d = send_q + CNT_W'(1);
        if (wrDoneFifoPush)  rcv_d  = rcv_q + CNT_W'(1);
        if (reqPush)         req_d  = req_q + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_EMPTY;
            rv_q      <= 2'b00;
            op_q      <= 4'b0000;
            wr_q      <= '0;
            drop_q    <= '0;
            err_q     <= 1'b0;
            exp_tid_q <= '0;
            send_q    <= '0;
            rcv_q     <= '0;
            req_q     <= '0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            rv_q      <= rv_d;
            op_q      <= op_d;
            wr_q      <= wr_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
            exp_tid_q <= exp_tid_d;
            send_q    <= send_d;
            rcv_q     <= rcv_d;
            req_q     <= req_d;
            ack_q     <= ack_d;
        end
    end

endmodule

// File: tb/tb_rdma_rx_dispatch.sv
// tb/tb_rdma_rx_dispatch.sv - self-checking bench for rdma_rx_dispatch
// Pushes are matched against a scoreboard queue filled when each header is driven.
module tb_rdma_rx_dispatch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        hdrValid = 1'b0;
    logic        hdrReady;
    logic [15:0] hdrControl = '0;
    logic [51:0] hdrWR = '0;
    logic        reqPush, ackFifoPush, offloadFifoPush, wrDoneFifoPush;
    logic [51:0] reqData;
    logic [27:0] ackFifoDataIn;
    logic [7:0]  offloadFifoDataIn, wrDoneFifoDataIn, dropCnt;
    logic        reqFull = 1'b0, ackFifoFull = 1'b0, offloadFifoFull = 1'b0, wrDoneFifoFull = 1'b0;
    logic        ackSeqErr;
    logic [15:0] sendCnt, rcvCnt, reqCnt, ackCnt;

    rdma_rx_dispatch #(.TID_W(4), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .hdrValid(hdrValid), .hdrReady(hdrReady), .hdrControl(hdrControl), .hdrWR(hdrWR),
        .reqPush(reqPush), .reqData(reqData), .reqFull(reqFull),
        .ackFifoPush(ackFifoPush), .ackFifoDataIn(ackFifoDataIn), .ackFifoFull(ackFifoFull),
        .offloadFifoPush(offloadFifoPush), .offloadFifoDataIn(offloadFifoDataIn),
        .offloadFifoFull(offloadFifoFull),
        .wrDoneFifoPush(wrDoneFifoPush), .wrDoneFifoDataIn(wrDoneFifoDataIn),
        .wrDoneFifoFull(wrDoneFifoFull),
        .dropCnt(dropCnt), .ackSeqErr(ackSeqErr),
        .sendCnt(sendCnt), .rcvCnt(rcvCnt), .reqCnt(reqCnt), .ackCnt(ackCnt)
    );

    always #5 clock = ~clock;

    // kind: 0 offload, 1 wrDone, 2 req, 3 ack, 4 drop
    typedef struct {
        logic [15:0] ctrl;
        logic [51:0] wr;
        int          kind;
        logic [51:0] exp_data;
    } vec_t;

    typedef struct {
        int          kind;
        logic [51:0] data;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_push(input int kind, input logic [51:0] wr);
        sb_t e;
        e.kind = kind;
        case (kind)
            0, 1:    e.data = {44'd0, wr[51:44]};
            2:       e.data = wr;
            default: e.data = {24'd0, wr[51:24]};
        endcase
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        hdrValid = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic send(input logic [15:0] c, input logic [51:0] w, output int waited);
        logic acc;
        acc = 1'b0;
        waited = 0;
        hdrValid = 1'b1;
        hdrControl = c;
        hdrWR = w;
        while (!acc && waited < 50) begin
            @(negedge clock);
            acc = hdrReady;
            @(posedge clock);
            #1;
            waited++;
        end
        hdrValid = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(posedge clock);
        #1;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain_empty", sb_q.size(), 0);
    endtask

    // Push monitor: every push must match the oldest expected entry and never coincide with full.
    int          mon_np;
    sb_t         mon_e;
    logic [51:0] mon_d;
    logic [3:0]  mon_p;
    always @(negedge clock) begin
        if (reset) begin
            mon_p  = {ackFifoPush, reqPush, wrDoneFifoPush, offloadFifoPush};
            mon_np = 0;
            for (int k = 0; k < 4; k++) begin
                if (mon_p[k]) begin
                    mon_np++;
                    case (k)
                        0:       mon_d = {44'd0, offloadFifoDataIn};
                        1:       mon_d = {44'd0, wrDoneFifoDataIn};
                        2:       mon_d = reqData;
                        default: mon_d = {24'd0, ackFifoDataIn};
                    endcase
                    if (sb_q.size() == 0) begin
                        check("unexpected_push", k, 99);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("push_kind", k, mon_e.kind);
                        check("push_data", mon_d, mon_e.data);
                    end
                end
            end
            if (mon_np > 1) check("one_push", mon_np, 1);
            if ((offloadFifoPush && offloadFifoFull) || (wrDoneFifoPush && wrDoneFifoFull) ||
                (reqPush && reqFull) || (ackFifoPush && ackFifoFull))
                check("push_while_full", 1, 0);
        end
    end

    vec_t tbl[8];
    int   w;
    int   e_cnt[5];
    logic [51:0] wv;
    logic exp_err[4];
    logic [3:0] tids[4];

    initial begin
        tbl[0] = '{16'hFF00, 52'h5A123456789AB, 0, 52'h5A};
        tbl[1] = '{16'h0001, 52'hC3FEDCBA98765, 1, 52'hC3};
        tbl[2] = '{16'h0003, 52'h1234567890ABC, 2, 52'h1234567890ABC};
        tbl[3] = '{16'h0007, 52'h0ABCDEF012345, 3, 52'h0ABCDEF};
        tbl[4] = '{16'h0037, 52'h1000000000000, 3, 52'h1000000};
        tbl[5] = '{16'h0002, 52'hFFFFFFFFFFFFF, 4, 52'h0};
        tbl[6] = '{16'h0080, 52'h5A123456789AB, 4, 52'h0};
        tbl[7] = '{16'h0007, 52'h2FFFFFFFFFFFF, 3, 52'h2FFFFFF};

        // reset values
        do_reset();
        @(negedge clock);
        check("rst_ready", hdrReady, 1);
        check("rst_push", {ackFifoPush, reqPush, wrDoneFifoPush, offloadFifoPush}, 0);
        check("rst_data", {reqData, ackFifoDataIn, offloadFifoDataIn, wrDoneFifoDataIn}, 0);
        check("rst_cnt", {sendCnt, rcvCnt, reqCnt, ackCnt, dropCnt, ackSeqErr}, 0);

        // SEND A5: push one cycle after acceptance
        do_reset();
        wv = 52'hA500000000000;
        expect_push(0, wv);
        send(16'h0000, wv, w);
        @(negedge clock);
        check("send_lat_push", offloadFifoPush, 1);
        check("send_lat_data", offloadFifoDataIn, 8'hA5);
        @(posedge clock);
        #1;
        check("send_cnt", sendCnt, 1);
        drain();

        // table of mixed headers, back-to-back
        do_reset();
        for (int k = 0; k < 5; k++) e_cnt[k] = 0;
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].kind < 4) sb_q.push_back('{tbl[i].kind, tbl[i].exp_data});
            e_cnt[tbl[i].kind]++;
            send(tbl[i].ctrl, tbl[i].wr, w);
            check("tbl_no_stall", w, 1);
        end
        drain();
        check("tbl_send_cnt", sendCnt, e_cnt[0]);
        check("tbl_rcv_cnt", rcvCnt, e_cnt[1]);
        check("tbl_req_cnt", reqCnt, e_cnt[2]);
        check("tbl_ack_cnt", ackCnt, e_cnt[3]);
        check("tbl_drop_cnt", dropCnt, e_cnt[4]);
        check("tbl_seq_err", ackSeqErr, 0);

        // REQ, ACK(TID0), RCV back-to-back
        do_reset();
        wv = 52'h7777777777777; expect_push(2, wv); send(16'h0003, wv, w); check("b2b_req", w, 1);
        wv = 52'h0123456789ABC; expect_push(3, wv); send(16'h0007, wv, w); check("b2b_ack", w, 1);
        wv = 52'h9876543210FED; expect_push(1, wv); send(16'h0001, wv, w); check("b2b_rcv", w, 1);
        drain();

        // ACK held under ackFifoFull for 5 cycles, REQ waiting behind it
        do_reset();
        ackFifoFull = 1'b1;
        wv = 52'h0FACE00000000; expect_push(3, wv); send(16'h0007, wv, w);
        wv = 52'h3333333333333; expect_push(2, wv);
        hdrValid = 1'b1; hdrControl = 16'h0003; hdrWR = wv;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall_ready", hdrReady, 0);
            check("stall_nopush", ackFifoPush, 0);
            @(posedge clock);
            #1;
        end
        ackFifoFull = 1'b0;
        @(negedge clock);
        check("unstall_push", ackFifoPush, 1);
        check("unstall_ready", hdrReady, 1);
        @(posedge clock);
        #1 hdrValid = 1'b0;
        drain();

        // ACK order check: TIDs 0,1,3,4
        do_reset();
        tids[0] = 4'd0; tids[1] = 4'd1; tids[2] = 4'd3; tids[3] = 4'd4;
        exp_err[0] = 1'b0; exp_err[1] = 1'b0; exp_err[2] = 1'b0; exp_err[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wv = {tids[i], 48'h00C0FFEE0000};
            expect_push(3, wv);
            send(16'h0007, wv, w);
            check("seq_err_step", ackSeqErr, exp_err[i]);
        end
        drain();
        check("seq_err_sticky", ackSeqErr, 1);
        check("seq_ack_cnt", ackCnt, 4);

        // drops: bad opcode, RV=01 SEND, then 300 more; saturates at 255
        do_reset();
        send(16'h000F, 52'h1, w);
        check("drop_cnt_0", dropCnt, 0);
        send(16'h0040, 52'h2, w);
        check("drop_cnt_1", dropCnt, 1);
        for (int i = 2; i < 302; i++) begin
            send((i % 2 == 0) ? 16'h00C3 : 16'h0005, 52'(i), w);
            check("drop_cnt_seq", dropCnt, (i > 255) ? 255 : i);
        end
        @(posedge clock);
        #1;
        check("drop_cnt_sat", dropCnt, 255);
        check("drop_no_counts", {sendCnt, rcvCnt, reqCnt, ackCnt}, 0);

        // reset mid-hold discards the held header
        do_reset();
        reqFull = 1'b1;
        send(16'h0003, 52'hBEEFBEEFBEEF1, w);
        @(negedge clock);
        check("hold_nopush", reqPush, 0);
        check("hold_ready", hdrReady, 0);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_ready", hdrReady, 1);
        check("mid_rst_data", reqData, 0);
        check("mid_rst_push", {ackFifoPush, reqPush, wrDoneFifoPush, offloadFifoPush}, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        reqFull = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("mid_rst_req_cnt", reqCnt, 0);
        check("mid_rst_sb", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
